// File: rtl/second_diff_integrator.sv
// Double integrator rebuilding x[n] = d[n] + 2*x[n-1] - x[n-2] per frame. Latency 1 cycle, IN_READY drops while an output stalls.
// Saturating output format when SECOND_DIFF_INTEGRATOR_SATURATE_EN is defined, two's-complement wrap otherwise.
module second_diff_integrator #(
    parameter int DIN_W     = 16,
    parameter int DOUT_W    = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic [DIN_W-1:0]  IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DOUT_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_LAST,
    output logic [7:0]        FRAME_CNT
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  x1_q, x1_d;
    logic [ACC_W-1:0]  x2_q, x2_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;

    logic              accept;
    logic              xfer;
    logic [ACC_W-1:0]  d_ext;
    logic [ACC_W-1:0]  y;
    logic [DOUT_W-1:0] y_fmt;

    assign IN_READY = RST & ~CLR & (~vld_q | OUT_READY);
    assign accept   = IN_VALID & IN_READY;
    assign xfer     = vld_q & OUT_READY;

    assign d_ext = {{(ACC_W-DIN_W){IN_DATA[DIN_W-1]}}, IN_DATA};
    assign y     = d_ext + {x1_q[ACC_W-2:0], 1'b0} - x2_q;

`ifdef SECOND_DIFF_INTEGRATOR_SATURATE_EN
    logic in_range;

    // Y fits DOUT_W when all bits from the output sign bit upward agree.
    assign in_range = (&y[ACC_W-1:DOUT_W-1]) | ~(|y[ACC_W-1:DOUT_W-1]);

    always_comb begin
        y_fmt = y[DOUT_W-1:0];
        if (!in_range) begin
            y_fmt = y[ACC_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}}
                               : {1'b0, {(DOUT_W-1){1'b1}}};
        end
    end
`else
    assign y_fmt = y[DOUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        last_d  = last_q;

        if (xfer) begin
            vld_d = 1'b0;
        end

        if (CLR) begin
            // Pending output is left alone; only the frame history restarts.
            x1_d    = '0;
            x2_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (accept) begin
            vld_d  = 1'b1;
            dout_d = y_fmt;
            x1_d   = y;
            x2_d   = x1_q;
            last_d = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d   = 8'd1;
                    state_d = RUN;
                end
                RUN: begin
                    if (cnt_q == LAST_IDX) begin
                        last_d  = 1'b1;
                        cnt_d   = '0;
                        x1_d    = '0;
                        x2_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            x1_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign OUT_DATA  = dout_q;
    assign OUT_VALID = vld_q;
    assign OUT_LAST  = last_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_second_diff_integrator.sv
// Bench for second_diff_integrator: two instances (FRAME_LEN 4 and 256) share one stimulus stream;
// a closed-form per-frame model x[n] = sum (n-k+1)*d[k] is checked every cycle.
module tb_second_diff_integrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_vld;
    logic        ordy;
    logic [15:0] din;

    logic        irdy_a, ovld_a, olast_a;
    logic [15:0] odat_a;
    logic [7:0]  fcnt_a;
    logic        irdy_b, ovld_b, olast_b;
    logic [15:0] odat_b;
    logic [7:0]  fcnt_b;

    always #5 clk = ~clk;

    second_diff_integrator #(.DIN_W(16), .DOUT_W(16), .ACC_W(24), .FRAME_LEN(4)) u_dut4 (
        .CLK(clk), .RST(rst_n), .CLR(clr),
        .IN_DATA(din), .IN_VALID(in_vld), .IN_READY(irdy_a),
        .OUT_DATA(odat_a), .OUT_VALID(ovld_a), .OUT_READY(ordy),
        .OUT_LAST(olast_a), .FRAME_CNT(fcnt_a)
    );

    second_diff_integrator #(.DIN_W(16), .DOUT_W(16), .ACC_W(24), .FRAME_LEN(256)) u_dut256 (
        .CLK(clk), .RST(rst_n), .CLR(clr),
        .IN_DATA(din), .IN_VALID(in_vld), .IN_READY(irdy_b),
        .OUT_DATA(odat_b), .OUT_VALID(ovld_b), .OUT_READY(ordy),
        .OUT_LAST(olast_b), .FRAME_CNT(fcnt_b)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    int          flen [2] = '{4, 256};
    int          fr   [2][256];
    int          pos  [2] = '{0, 0};
    bit          m_vld = 1'b0;
    logic [15:0] m_dat [2] = '{16'd0, 16'd0};
    bit          m_last [2] = '{1'b0, 1'b0};

    bit          rpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          pc = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fmt(input logic [23:0] y);
        int v;
        v = int'($signed(y));
`ifdef SECOND_DIFF_INTEGRATOR_SATURATE_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    // Closed form of the double integrator over the current frame, reduced mod 2^24.
    function automatic logic [15:0] model_y(input int i);
        longint s;
        longint t;
        int     n;
        s = 0;
        n = pos[i] - 1;
        for (int k = 0; k <= n; k++) s += longint'(n - k + 1) * longint'(fr[i][k]);
        t = s;
        return fmt(t[23:0]);
    endfunction

    initial begin
        bit rdy;
        bit acc;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                rdy = rst_n && !clr && (!m_vld || ordy);
                chk("in_ready4",   irdy_a, rdy);
                chk("in_ready256", irdy_b, rdy);
                chk("out_valid4",   ovld_a, m_vld);
                chk("out_valid256", ovld_b, m_vld);
                chk("out_data4",   $signed(odat_a), $signed(m_dat[0]));
                chk("out_data256", $signed(odat_b), $signed(m_dat[1]));
                chk("out_last4",   olast_a, m_last[0]);
                chk("out_last256", olast_b, m_last[1]);
                chk("frame_cnt4",   fcnt_a, pos[0]);
                chk("frame_cnt256", fcnt_b, pos[1]);

                if (!rst_n) begin
                    m_vld = 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        pos[i] = 0; m_dat[i] = 16'd0; m_last[i] = 1'b0;
                    end
                end else begin
                    acc = in_vld && rdy;
                    if (clr) begin
                        pos[0] = 0; pos[1] = 0;
                    end
                    if (acc) begin
                        for (int i = 0; i < 2; i++) begin
                            fr[i][pos[i]] = int'($signed(din));
                            pos[i]++;
                            m_dat[i]  = model_y(i);
                            m_last[i] = (pos[i] == flen[i]);
                            if (m_last[i]) pos[i] = 0;
                        end
                        m_vld = 1'b1;
                    end else if (m_vld && ordy) begin
                        m_vld = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int d, input bit v, input bit r);
        din = d[15:0]; in_vld = v; ordy = r;
        cyc();
    endtask

    task automatic do_reset();
        in_vld = 1'b0; clr = 1'b0; ordy = 1'b1;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic send(input int d);
        bit took;
        took = 1'b0;
        in_vld = 1'b1; din = d[15:0];
        for (int t = 0; t < 16 && !took; t++) begin
            ordy = rpat[pc % 5];
            pc++;
            @(negedge clk);
            took = irdy_b;
            cyc();
        end
        chk("send_accept", took, 1);
    endtask

    initial begin
        int e256 [6] = '{1, 3, 6, 10, 15, 21};
        int e4   [6] = '{1, 3, 6, 10, 1, 3};
        bit l4   [6] = '{0, 0, 0, 1, 0, 0};
        int imp_d [4] = '{5, 0, 0, 0};
        int imp_e [4] = '{5, 10, 15, 20};
        int mix  [10] = '{7, -3, 100, -250, 0, 12, -1, 30000, -30000, 5};
        int ovf_exp;

        rst_n = 1'b0; clr = 1'b0; in_vld = 1'b0; ordy = 1'b1; din = 16'd0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst_n = 1'b1;

        // constant input and frame wrap on the 4-sample instance
        for (int j = 0; j < 6; j++) begin
            put(1, 1'b1, 1'b1);
            chk("const256", $signed(odat_b), e256[j]);
            chk("frame4", $signed(odat_a), e4[j]);
            chk("frame4_last", olast_a, l4[j]);
            if (j == 3) chk("frame4_cnt_wrap", fcnt_a, 0);
        end

        // impulse
        do_reset();
        for (int j = 0; j < 4; j++) begin
            put(imp_d[j], 1'b1, 1'b1);
            chk("impulse", $signed(odat_b), imp_e[j]);
        end
        chk("impulse_last4", olast_a, 1);

        // backpressure
        do_reset();
        put(1, 1'b1, 1'b0);
        chk("bp_first", $signed(odat_b), 1);
        chk("bp_in_ready", irdy_b, 0);
        put(1, 1'b1, 1'b0);
        put(1, 1'b1, 1'b0);
        chk("bp_hold", $signed(odat_b), 1);
        chk("bp_hold_vld", ovld_b, 1);
        put(1, 1'b1, 1'b1);
        chk("bp_resume1", $signed(odat_b), 3);
        put(1, 1'b1, 1'b1);
        chk("bp_resume2", $signed(odat_b), 6);
        put(0, 1'b0, 1'b1);
        chk("bp_drain", ovld_b, 0);

        // CLR mid-frame
        do_reset();
        for (int j = 0; j < 3; j++) put(1, 1'b1, 1'b1);
        chk("clr_pre", $signed(odat_b), 6);
        clr = 1'b1;
        put(1, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_no_accept", ovld_b, 0);
        chk("clr_cnt", fcnt_b, 0);
        put(1, 1'b1, 1'b1);
        chk("clr_next1", $signed(odat_b), 1);
        put(1, 1'b1, 1'b1);
        chk("clr_next2", $signed(odat_b), 3);
        chk("clr_cnt2", fcnt_b, 2);

        // reset mid-frame
        put(0, 1'b0, 1'b1);
        put(1, 1'b1, 1'b1);
        put(1, 1'b1, 1'b1);
        rst_n = 1'b0;
        put(1, 1'b1, 1'b1);
        chk("rst_vld", ovld_b, 0);
        chk("rst_cnt", fcnt_b, 0);
        rst_n = 1'b1;
        put(1, 1'b1, 1'b1);
        chk("rst_next", $signed(odat_b), 1);

        // mixed signs under toggling OUT_READY
        do_reset();
        foreach (mix[j]) send(mix[j]);
        put(0, 1'b0, 1'b1);
        put(0, 1'b0, 1'b1);

        // overflow at the end of a 256-sample frame
`ifdef SECOND_DIFF_INTEGRATOR_SATURATE_EN
        ovf_exp = 32767;
`else
        ovf_exp = -32640;
`endif
        do_reset();
        for (int j = 0; j < 256; j++) begin
            put(1, 1'b1, 1'b1);
            if (j == 254) chk("ovf_254", $signed(odat_b), 32640);
            if (j == 255) begin
                chk("ovf_255", $signed(odat_b), ovf_exp);
                chk("ovf_last", olast_b, 1);
                chk("ovf_cnt", fcnt_b, 0);
            end
        end
        put(0, 1'b0, 1'b1);
        put(0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
